// File: rtl/result_streamer.sv
// Streams the binarised result memory to the host link, 8 pixels per byte (MSB = first pixel).
// Runs once per reset after global_state reaches the output phase; finished is sticky.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for global_state==3 with finished low
// S_FETCH | issuing 8 reads, shifting in data one cycle behind the address
// S_SEND  | byte held on oTxData/oTxValid until the sink accepts it
// S_DONE  | all bytes accepted; no further reads or bytes until reset
module result_streamer #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int WIDTH       = 2**WIDTH_BITS,
    parameter int HEIGHT      = 2**HEIGHT_BITS
) (
    input  logic                   clock,
    input  logic                   not_reset,
    input  logic [2:0]             global_state,
    output logic [WIDTH_BITS-1:0]  oResultCol,
    output logic [HEIGHT_BITS-1:0] oResultRow,
    input  logic                   iResultData,
    output logic [7:0]             oTxData,
    output logic                   oTxValid,
    input  logic                   iTxReady,
    output logic                   finished
);

    localparam int POS_W     = WIDTH_BITS + HEIGHT_BITS;
    localparam int NUM_BYTES = (WIDTH * HEIGHT) / 8;
    localparam int BC_W      = (POS_W > 3) ? (POS_W - 3) : 1;
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NUM_BYTES - 1);
    localparam logic [2:0] OUTPUT_PHASE = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [3:0]        issue_cnt_q, issue_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              finished_q, finished_d;

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            issue_cnt_q <= '0;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            issue_cnt_q <= issue_cnt_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            finished_q  <= finished_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        issue_cnt_d = issue_cnt_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        finished_d  = finished_q;

        case (state_q)
            S_IDLE: begin
                if (global_state == OUTPUT_PHASE && !finished_q) begin
                    issue_cnt_d = '0;
                    state_d     = S_FETCH;
                end
            end

            S_FETCH: begin
                // issue_cnt counts cycles in this byte; the bit read at count k-1 arrives at count k
                if (issue_cnt_q != 4'd0) begin
                    shift_d = {shift_q[6:0], iResultData};
                end
                if (issue_cnt_q < 4'd8) begin
                    pos_d       = pos_q + POS_W'(1);
                    issue_cnt_d = issue_cnt_q + 4'd1;
                end else begin
                    tx_data_d   = {shift_q[6:0], iResultData};
                    tx_valid_d  = 1'b1;
                    issue_cnt_d = '0;
                    state_d     = S_SEND;
                end
            end

            S_SEND: begin
                if (tx_valid_q && iTxReady) begin
                    tx_valid_d = 1'b0;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        finished_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                        state_d    = S_FETCH;
                    end
                end
            end

            S_DONE: begin
                tx_valid_d = 1'b0;
                pos_d      = '0;
                finished_d = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign oResultCol = pos_q[WIDTH_BITS-1:0];
    assign oResultRow = pos_q[POS_W-1 -: HEIGHT_BITS];
    assign oTxData    = tx_data_q;
    assign oTxValid   = tx_valid_q;
    assign finished   = finished_q;

endmodule

// File: tb/tb_result_streamer.sv
// Bench for result_streamer on a 8x4 image: directed table, random images, reset and idle sequences.
// Expected bytes come from packing the bench's own pixel array.
module tb_result_streamer;

    logic       clock;
    logic       not_reset;
    logic [2:0] global_state;
    logic [2:0] oResultCol;
    logic [1:0] oResultRow;
    logic       iResultData;
    logic [7:0] oTxData;
    logic       oTxValid;
    logic       iTxReady;
    logic       finished;

    logic       mem [0:31];
    logic [4:0] addr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] img;
        int          stall;
        int          gs_drop;
        logic [31:0] exp_stream;
    } vec_t;

    vec_t vecs [6];

    result_streamer #(
        .WIDTH_BITS (3),
        .HEIGHT_BITS(2)
    ) dut (
        .clock       (clock),
        .not_reset   (not_reset),
        .global_state(global_state),
        .oResultCol  (oResultCol),
        .oResultRow  (oResultRow),
        .iResultData (iResultData),
        .oTxData     (oTxData),
        .oTxValid    (oTxValid),
        .iTxReady    (iTxReady),
        .finished    (finished)
    );

    always #5 clock = ~clock;

    assign addr = {oResultRow, oResultCol};

    // synchronous-read result memory
    always @(posedge clock) iResultData <= mem[addr];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic load_img(input logic [31:0] img);
        for (int p = 0; p < 32; p++) mem[p] = img[31-p];
    endtask

    // reference: byte b holds pixels 8b..8b+7, first pixel in bit 7
    function automatic logic [31:0] model_stream();
        logic [31:0] s;
        logic [7:0]  by;
        s = '0;
        for (int b = 0; b < 4; b++) begin
            by = '0;
            for (int i = 0; i < 8; i++) by = by | (8'(mem[b*8+i]) << (7 - i));
            s = {s[23:0], by};
        end
        return s;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 32'(oTxValid), 0);
        chk({tag, "_finished"}, 32'(finished), 0);
        chk({tag, "_addr"}, 32'(addr), 0);
        chk({tag, "_data"}, 32'(oTxData), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 not_reset = 1'b0;
        #1 check_reset_values("reset");
        @(negedge clock);
        not_reset = 1'b1;
    endtask

    // Starts the stream (global_state=3 at a falling edge) and handles every byte.
    // stall = cycles ready is held low after each valid rises; gs_drop = byte index during
    // whose fetch global_state is pulled to 0 (-1: never).
    task automatic stream(input int stall, input int gs_drop, input logic [31:0] exp);
        int          cyc;
        int          nbytes;
        int          wait_cnt;
        int          next_valid;
        int          quiet_bad;
        logic [7:0]  held;
        logic [4:0]  held_addr;
        logic [7:0]  exp_byte;
        cyc        = 0;
        nbytes     = 0;
        wait_cnt   = 0;
        next_valid = 10;
        held       = '0;
        held_addr  = '0;
        global_state = 3'd3;
        iTxReady     = (stall == 0);
        while (nbytes < 4 && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (gs_drop >= 0 && nbytes == gs_drop && !oTxValid) global_state = 3'd0;
            if (oTxValid) begin
                if (wait_cnt == 0) begin
                    exp_byte = exp[31 - 8*nbytes -: 8];
                    chk("valid_latency", cyc, next_valid);
                    chk("byte_value", 32'(oTxData), 32'(exp_byte));
                    chk("finished_early", 32'(finished), 0);
                    held      = oTxData;
                    held_addr = addr;
                end else begin
                    chk("stall_hold", {oTxData, 3'b0, addr}, {held, 3'b0, held_addr});
                end
                if (wait_cnt < stall) begin
                    iTxReady = 1'b0;
                    wait_cnt++;
                end else begin
                    iTxReady   = 1'b1;
                    nbytes++;
                    wait_cnt   = 0;
                    next_valid = cyc + 10;
                end
            end else if (stall != 0) begin
                iTxReady = 1'($urandom_range(0, 1));
            end
        end
        chk("byte_count", nbytes, 4);
        @(negedge clock);
        chk("finished_after_last", {31'(0), finished}, 1);
        chk("valid_after_last", 32'(oTxValid), 0);
        global_state = 3'd3;
        iTxReady     = 1'b1;
        quiet_bad    = 0;
        repeat (50) begin
            @(negedge clock);
            if (oTxValid || addr != 0 || !finished) quiet_bad++;
        end
        chk("done_quiet", quiet_bad, 0);
    endtask

    initial begin
        int idle_bad;
        int hs;
        int budget;
        logic [31:0] rimg;

        clock        = 1'b0;
        not_reset    = 1'b0;
        global_state = 3'd0;
        iTxReady     = 1'b0;
        for (int p = 0; p < 32; p++) mem[p] = 1'b0;

        vecs[0] = '{img: 32'hA53CFF01, stall: 0, gs_drop: -1, exp_stream: 32'hA53CFF01};
        vecs[1] = '{img: 32'hA53CFF01, stall: 5, gs_drop: -1, exp_stream: 32'hA53CFF01};
        vecs[2] = '{img: 32'hA53CFF01, stall: 0, gs_drop: 1,  exp_stream: 32'hA53CFF01};
        vecs[3] = '{img: 32'h00000000, stall: 1, gs_drop: -1, exp_stream: 32'h00000000};
        vecs[4] = '{img: 32'hFFFFFFFF, stall: 3, gs_drop: 2,  exp_stream: 32'hFFFFFFFF};
        vecs[5] = '{img: 32'h80000001, stall: 2, gs_drop: -1, exp_stream: 32'h80000001};

        repeat (3) @(negedge clock);
        check_reset_values("por");
        not_reset = 1'b1;

        load_img(vecs[0].img);
        global_state = 3'd2;
        iTxReady     = 1'b1;
        idle_bad     = 0;
        repeat (20) begin
            @(negedge clock);
            if (oTxValid || addr != 0) idle_bad++;
        end
        chk("idle_gs2", idle_bad, 0);

        for (int i = 0; i < 6; i++) begin
            load_img(vecs[i].img);
            stream(vecs[i].stall, vecs[i].gs_drop, vecs[i].exp_stream);
            do_reset();
        end

        // reset while the second byte is waiting in SEND
        load_img(32'hA53CFF01);
        global_state = 3'd3;
        iTxReady     = 1'b1;
        hs           = 0;
        budget       = 0;
        while (budget < 100) begin
            @(negedge clock);
            budget++;
            if (oTxValid) begin
                if (hs == 0) begin
                    hs = 1;
                end else begin
                    iTxReady = 1'b0;
                    break;
                end
            end
        end
        chk("midsend_reached", 32'(oTxValid), 1);
        chk("midsend_byte", 32'(oTxData), 32'h3C);
        #2 not_reset = 1'b0;
        #1 check_reset_values("midsend_reset");
        @(negedge clock);
        not_reset = 1'b1;
        stream(0, -1, 32'hA53CFF01);
        do_reset();

        for (int r = 0; r < 6; r++) begin
            for (int p = 0; p < 32; p++) mem[p] = 1'($urandom_range(0, 1));
            rimg = model_stream();
            stream(int'($urandom_range(0, 4)), -1, rimg);
            do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_streamer.md
Name: result_streamer

Overview:
- Reads the 1-bit binarised result memory in raster order after thresholding completes (global_state 3).
- Packs 8 consecutive pixels per byte, MSB first.
- Emits bytes on a valid/ready byte stream toward the host-link transmitter (UART TX FIFO).
- Asserts a sticky finished flag once the final byte has been accepted.

Parameters:
WIDTH_BITS, 8, bits of pixel X coordinate (must be >= 3)
HEIGHT_BITS, 8, bits of pixel Y coordinate
WIDTH, 2**WIDTH_BITS, image width in pixels
HEIGHT, 2**HEIGHT_BITS, image height in pixels

Ports:
clock  input  1  system clock, all logic on rising edge
not_reset  input  1  asynchronous, active-low reset
global_state  input  3  global processing state; 3 = result output phase
oResultCol  output  WIDTH_BITS  result memory read X address
oResultRow  output  HEIGHT_BITS  result memory read Y address
iResultData  input  1  result memory read data, valid 1 cycle after address (synchronous read)
oTxData  output  8  packed byte; bit7 = lowest-addressed pixel of the group
oTxValid  output  1  oTxData holds a byte awaiting acceptance
iTxReady  input  1  sink can accept a byte this cycle
finished  output  1  sticky: all WIDTH*HEIGHT/8 bytes accepted

Behaviour:
- Reset (async, not_reset low): state=IDLE; pos=0; oResultCol/oResultRow=0; oTxData=0; oTxValid=0; finished=0; shift register and counters=0. Reset mid-transfer aborts immediately, with no partial byte retained.
- Address: {oResultRow,oResultCol} = pos (row = upper HEIGHT_BITS, col = lower WIDTH_BITS). pos width WIDTH_BITS+HEIGHT_BITS, linear raster index.
- States:
  - IDLE: if global_state==3 && !finished -> FETCH. Otherwise stay.
  - FETCH: issue 8 reads on 8 consecutive cycles (pos increments each cycle, issue count 0..7). Each data bit is captured one cycle after its address and shifted in from the LSB side, so the first pixel ends in bit7. When the 8th bit is captured (9th FETCH-related cycle), load oTxData and set oTxValid=1 -> SEND.
  - SEND: hold oTxData and oTxValid stable while iTxReady=0. On oTxValid&&iTxReady, transfer occurs and oTxValid clears next cycle. If the accepted byte was the last (byte index WIDTH*HEIGHT/8-1) -> DONE. Else -> FETCH.
  - DONE: finished=1 (sticky until reset); oTxValid=0; pos=0 (wrapped). No further reads or bytes regardless of global_state.
- Latency: from the first FETCH cycle to oTxValid high = 9 cycles. With iTxReady held high, one byte is accepted every 10 cycles.
- global_state is sampled only in IDLE. Once started, the stream runs to completion even if global_state leaves 3, because oTxValid may never drop without a transfer.
- Address wrap: pos increments from WIDTH*HEIGHT-1 to 0 during the last FETCH. This is legal; no read is issued in DONE.
- iTxReady asserted while oTxValid=0 has no effect. Ready-before-valid and valid-before-ready are both legal.
- No byte is skipped or duplicated. Total bytes emitted = WIDTH*HEIGHT/8 exactly.
- oTxData retains the last sent byte after the transfer until the next load.

Test Plan:
- WIDTH_BITS=3, HEIGHT_BITS=2 (32 px), memory row-major = 0xA5,0x3C,0xFF,0x01, iTxReady=1, global_state=3 -> bytes 0xA5,0x3C,0xFF,0x01 in order; first oTxValid 9 cycles after FETCH entry; finished rises after the 4th handshake; total 4 transfers.
- Same image, iTxReady low for 5 cycles each time oTxValid rises -> oTxData/oTxValid stable throughout each stall; same 4 bytes; no address advance during SEND.
- global_state=2 for 20 cycles, then 3 -> no reads issued, oTxValid=0 while at 2; streaming starts on the first cycle at 3.
- global_state switched 3->0 mid-byte 2 -> stream still completes all 4 bytes, finished=1.
- not_reset pulsed low during SEND of byte 2 -> oTxValid=0, finished=0, addresses 0 immediately. With global_state=3 after release, the stream restarts from byte 0xA5.
- After finished=1, hold global_state=3 for 50 cycles with iTxReady=1 -> no oTxValid, address stays 0, finished stays 1.
